// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave register block: command codes,
// STATUS bit positions, frame phase encoding and the byte width.
package spi_slave_pkg;

  localparam int SPI_DW = 8;

  typedef enum logic [7:0] {
    CMD_WR_ADDR   = 8'h01,
    CMD_WR_DATA   = 8'h02,
    CMD_RD_DOUT   = 8'h03,
    CMD_SAMPLE    = 8'h04,
    CMD_RD_STATUS = 8'h05
  } cmd_e;

  localparam int ST_BUSY      = 0;
  localparam int ST_DVALID    = 1;
  localparam int ST_ERR_ILL   = 2;
  localparam int ST_ERR_SHORT = 3;

  localparam logic PH_CMD  = 1'b0;
  localparam logic PH_DATA = 1'b1;

  function automatic logic cmd_legal(input logic [7:0] c);
    return (c == CMD_WR_ADDR) || (c == CMD_WR_DATA) ||
           (c == CMD_RD_DOUT) || (c == CMD_SAMPLE) ||
           (c == CMD_RD_STATUS);
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// Bit counter, rx/tx shift registers, byte-done pulse and short-byte
// detect for the SPI slave; everything runs on posedge SCK.
import spi_slave_pkg::*;

module spi_slave_shifter (
  input  logic              SCK,
  input  logic              reset,
  input  logic              SSB,
  input  logic              MOSI,
  input  logic              phase,
  input  logic              tx_load,
  input  logic [SPI_DW-1:0] tx_val,
  output logic              MISO,
  output logic              byte_done,
  output logic [SPI_DW-1:0] rx_byte,
  output logic              short_byte
);

  logic [3:0]        cnt_q;
  logic [SPI_DW-2:0] rx_q;
  logic [SPI_DW-1:0] tx_q;
  logic              cnt_full;

  assign cnt_full   = (cnt_q == 4'd8);
  assign rx_byte    = {rx_q, MOSI};
  assign byte_done  = !SSB && (cnt_q == 4'd7);
  assign short_byte = SSB && (cnt_q != 4'd0) && !cnt_full;
  assign MISO       = !SSB && tx_q[SPI_DW-1];

  always_ff @(posedge SCK) begin
    if (reset) begin
      cnt_q <= '0;
      rx_q  <= '0;
      tx_q  <= '0;
    end else begin
      if (SSB) begin
        cnt_q <= '0;
      end else if (!cnt_full) begin
        cnt_q <= cnt_q + 4'd1;
        rx_q  <= rx_byte[SPI_DW-2:0];
      end
      // Load happens only at a command byte end, so it never meets a shift.
      if (tx_load) begin
        tx_q <= tx_val;
      end else if (!SSB && phase == PH_DATA && !cnt_full) begin
        tx_q <= {tx_q[SPI_DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_slave_regs.sv
// SPI slave command decoder with address/write port and delayed sampler.
// Define SPI_SLAVE_ERR_STATUS_EN to add the sticky error flags to STATUS.
import spi_slave_pkg::*;

module spi_slave_regs #(
  parameter int DATA_WIDTH = SPI_DW
) (
  input  logic                  SCK,
  input  logic                  reset,
  input  logic                  SSB,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  logic                  phase_q;
  logic [DATA_WIDTH-1:0] cmd_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] smp_cnt_q;
  logic                  busy_q;
  logic                  dv_q;

  logic                  byte_done;
  logic                  short_byte;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic [DATA_WIDTH-1:0] tx_val;
  logic [DATA_WIDTH-1:0] status;
  logic [1:0]            err_bits;
  logic                  cmd_done;
  logic                  data_done;

  assign cmd_done  = byte_done && (phase_q == PH_CMD);
  assign data_done = byte_done && (phase_q == PH_DATA);

  spi_slave_shifter u_shifter (
    .SCK        (SCK),
    .reset      (reset),
    .SSB        (SSB),
    .MOSI       (MOSI),
    .phase      (phase_q),
    .tx_load    (cmd_done),
    .tx_val     (tx_val),
    .MISO       (MISO),
    .byte_done  (byte_done),
    .rx_byte    (rx_byte),
    .short_byte (short_byte)
  );

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = busy_q;
    status[ST_DVALID]    = dv_q;
    status[ST_ERR_ILL]   = err_bits[0];
    status[ST_ERR_SHORT] = err_bits[1];
  end

  always_comb begin
    tx_val = '0;
    unique case (1'b1)
      (rx_byte == CMD_RD_STATUS): tx_val = status;
      (rx_byte == CMD_RD_DOUT):   tx_val = dout_q;
      default:                    tx_val = '0;
    endcase
  end

  always_ff @(posedge SCK) begin
    if (reset) begin
      phase_q   <= PH_CMD;
      cmd_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      smp_cnt_q <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (byte_done) phase_q <= ~phase_q;
      if (cmd_done) cmd_q <= rx_byte;
      if (data_done) begin
        unique case (1'b1)
          (cmd_q == CMD_WR_ADDR): addr_q <= rx_byte;
          (cmd_q == CMD_WR_DATA): begin
            wr_en   <= 1'b1;
            wr_addr <= addr_q;
            wr_data <= rx_byte;
            addr_q  <= addr_q + 1'b1;
          end
          (cmd_q == CMD_SAMPLE): begin
            if (!busy_q) begin
              busy_q    <= 1'b1;
              smp_cnt_q <= rx_byte;
            end
          end
          (cmd_q == CMD_RD_DOUT): dv_q <= 1'b0;
          default: ;
        endcase
      end
      // Placed after the decode so a same-edge capture overrides the clear.
      if (busy_q) begin
        if (smp_cnt_q == '0) begin
          dout_q <= sample_in;
          dv_q   <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          smp_cnt_q <= smp_cnt_q - 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_ERR_STATUS_EN
  logic err_ill_q;
  logic err_short_q;

  assign err_bits = {err_short_q, err_ill_q};

  always_ff @(posedge SCK) begin
    if (reset) begin
      err_ill_q   <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      if (data_done && cmd_q == CMD_RD_STATUS) begin
        err_ill_q   <= 1'b0;
        err_short_q <= 1'b0;
      end
      if (cmd_done && !cmd_legal(rx_byte)) err_ill_q <= 1'b1;
      if (data_done && cmd_q == CMD_SAMPLE && busy_q) err_ill_q <= 1'b1;
      if (short_byte) err_short_q <= 1'b1;
    end
  end
`else
  logic unused_short;

  assign err_bits     = 2'b00;
  assign unused_short = short_byte;
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed plus random bench for spi_slave_regs against a cycle-count
// reference model of the command set and the delayed sampler.
module tb_spi_slave_regs;

  logic       SCK = 1'b0;
  logic       reset = 1'b1;
  logic       SSB = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       MISO;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_regs dut (
    .SCK       (SCK),
    .reset     (reset),
    .SSB       (SSB),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .sample_in (sample_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

`ifdef SPI_SLAVE_ERR_STATUS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 SCK = ~SCK;

  int cyc = 0;
  always @(posedge SCK) cyc++;

  int         wr_cnt = 0;
  int         wr_cyc = -1;
  logic [7:0] wr_a = 8'h00;
  logic [7:0] wr_d = 8'h00;
  always @(negedge SCK) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      wr_a   = wr_addr;
      wr_d   = wr_data;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] m_addr, m_dout, m_sval;
  logic       m_dv, m_pend, m_ill, m_short;
  int         m_cap;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_addr = 0; m_dout = 0; m_sval = 0; m_dv = 0;
    m_pend = 0; m_ill = 0; m_short = 0; m_cap = 0;
  endtask

  // Apply a pending capture once posedge number c has happened.
  task automatic settle(input int c);
    if (m_pend && c >= m_cap) begin
      m_dout = m_sval;
      m_dv   = 1'b1;
      m_pend = 1'b0;
    end
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0, ERR_EN & m_short, ERR_EN & m_ill, m_dv, m_pend};
  endfunction

  function automatic logic legal(input logic [7:0] c);
    return c >= 8'h01 && c <= 8'h05;
  endfunction

  // One SSB-low window of nbits, then one idle posedge with SSB high.
  task automatic xfer(input logic [7:0] b, input int nbits,
                      output logic [7:0] mi, output int last_edge);
    mi  = 8'h00;
    SSB = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      #1 mi = {mi[6:0], MISO};
      @(negedge SCK);
    end
    last_edge = cyc;
    SSB  = 1'b1;
    MOSI = 1'b0;
    #1 chk("miso_idle", MISO, 0);
    @(negedge SCK);
  endtask

  task automatic short_byte(input int nbits);
    logic [7:0] mi;
    int e;
    xfer(8'($urandom), nbits, mi, e);
    m_short = 1'b1;
  endtask

  task automatic pair(input logic [7:0] c, input logic [7:0] d,
                      output logic [7:0] rd);
    logic [7:0] mi, exp_tx, a0;
    int ec, ed, w0;
    w0 = wr_cnt;
    xfer(c, 8, mi, ec);
    chk("cmd_miso", mi, 0);
    settle(ec - 1);
    exp_tx = (c == 8'h05) ? m_status() : (c == 8'h03) ? m_dout : 8'h00;
    if (!legal(c)) m_ill = 1'b1;
    xfer(d, 8, rd, ed);
    chk("rd_miso", rd, exp_tx);
    settle(ed - 1);
    a0 = m_addr;
    case (c)
      8'h01: m_addr = d;
      8'h02: m_addr = a0 + 8'h01;
      8'h03: m_dv = 1'b0;
      8'h04: begin
        if (m_pend) m_ill = 1'b1;
        else begin
          m_pend = 1'b1;
          m_cap  = ed + int'(d) + 1;
          m_sval = sample_in;
        end
      end
      8'h05: begin m_ill = 1'b0; m_short = 1'b0; end
      default: ;
    endcase
    settle(ed);
    chk("wr_count", wr_cnt - w0, (c == 8'h02) ? 1 : 0);
    if (c == 8'h02) begin
      chk("wr_addr", wr_a, a0);
      chk("wr_data", wr_d, d);
      chk("wr_cycle", wr_cyc, ed);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge SCK);
    reset = 1'b0;
    m_reset();
    @(negedge SCK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] c, d;
    m_reset();
    repeat (3) @(negedge SCK);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_miso", MISO, 0);
    reset = 1'b0;
    @(negedge SCK);
    pair(8'h05, 8'h00, rd);
    chk("rst_status", rd, 8'h00);
    pair(8'h03, 8'h00, rd);
    chk("rst_dout", rd, 8'h00);

    pair(8'h01, 8'hAA, rd);
    pair(8'h02, 8'hBB, rd);
    chk("wr1_addr", wr_a, 8'hAA);
    chk("wr1_data", wr_d, 8'hBB);
    pair(8'h02, 8'h3C, rd);
    chk("addr_inc", wr_a, 8'hAB);

    sample_in = 8'h5C;
    pair(8'h04, 8'h03, rd);
    pair(8'h05, 8'h00, rd);
    chk("sample_status", rd, 8'h02);
    pair(8'h03, 8'hFF, rd);
    chk("sample_dout", rd, 8'h5C);
    pair(8'h05, 8'h00, rd);
    chk("dv_cleared", rd, 8'h00);

    // Busy edge cases: N=8 still busy at the next status load, N=7 not.
    pair(8'h04, 8'h08, rd);
    pair(8'h05, 8'h00, rd);
    chk("busy_n8", rd, 8'h01);
    repeat (4) @(negedge SCK);
    pair(8'h04, 8'h07, rd);
    pair(8'h05, 8'h00, rd);
    chk("busy_n7", rd, 8'h02);
    pair(8'h04, 8'h00, rd);
    pair(8'h03, 8'h00, rd);

    short_byte(5);
    pair(8'h01, 8'hDD, rd);
    pair(8'h05, 8'h00, rd);
    chk("short_status", rd, ERR_EN ? 8'h08 : 8'h00);
    pair(8'h02, 8'h01, rd);
    chk("short_addr", wr_a, 8'hDD);

    pair(8'h07, 8'h11, rd);
    pair(8'h01, 8'hFF, rd);
    pair(8'h05, 8'h00, rd);
    chk("ill_status", rd, ERR_EN ? 8'h04 : 8'h00);
    pair(8'h05, 8'h00, rd);
    chk("ill_cleared", rd, 8'h00);
    pair(8'h02, 8'h42, rd);
    chk("wrap_hi", wr_a, 8'hFF);
    pair(8'h02, 8'h43, rd);
    chk("wrap_lo", wr_a, 8'h00);

    sample_in = 8'hA7;
    pair(8'h04, 8'd200, rd);
    pair(8'h04, 8'd5, rd);
    pair(8'h05, 8'h00, rd);
    chk("busy_resample", rd, ERR_EN ? 8'h05 : 8'h01);
    short_byte(3);
    do_reset();
    pair(8'h05, 8'h00, rd);
    chk("rst_mid_status", rd, 8'h00);
    repeat (260) @(negedge SCK);
    pair(8'h05, 8'h00, rd);
    chk("no_late_capture", rd, 8'h00);
    pair(8'h03, 8'h00, rd);
    chk("rst_mid_dout", rd, 8'h00);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) short_byte($urandom_range(1, 7));
      repeat ($urandom_range(0, 3)) @(negedge SCK);
      settle(cyc);
      if (!m_pend) sample_in = 8'($urandom);
      case ($urandom_range(0, 7))
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3, 4: c = 8'h04;
        5: c = 8'h05;
        default: c = 8'($urandom);
      endcase
      d = (c == 8'h04) ? 8'($urandom_range(0, 25)) : 8'($urandom);
      pair(c, d, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the bits per SPI byte; only 8 is supported.
REQ-002 SHALL have port SCK, input, 1 bit: the only clock; all logic runs on posedge SCK.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SSB, input, 1 bit: active-low byte select; one byte per low window.
REQ-005 SHALL have port MOSI, input, 1 bit: serial data in, MSB first.
REQ-006 SHALL have port MISO, output, 1 bit: serial data out, MSB first.
REQ-007 SHALL have port sample_in, input, 8 bits: external value captured by the sample command.
REQ-008 SHALL have port wr_en, output, 1 bit: one-cycle write strobe.
REQ-009 SHALL have port wr_addr, output, 8 bits: write address, valid with wr_en.
REQ-010 SHALL have port wr_data, output, 8 bits: write data, valid with wr_en.

Function
REQ-011 SHALL sample MOSI on each posedge SCK with SSB=0 into the rx shift register (shift left, MOSI into bit 0), counting bits 0..8.
REQ-012 SHALL complete a byte at the posedge that captures bit 8; further posedges in the same SSB-low window are ignored.
REQ-013 SHALL, on SSB=1 with a bit count of 1..7, discard the partial byte and leave the frame phase unchanged; a count of 0 or 8 is not an error.
REQ-014 SHALL alternate the frame phase CMD -> DATA -> CMD on each completed byte, starting in CMD.
REQ-015 SHALL decode command bytes as follows: 0x01 WR_ADDR, 0x02 WR_DATA, 0x04 SAMPLE, 0x05 RD_STATUS, 0x03 RD_DOUT; any other value is illegal, and its data byte is consumed and ignored.
REQ-016 SHALL, on WR_ADDR data completion, load ADDR with the data byte on the same edge.
REQ-017 SHALL, on WR_DATA data completion, assert wr_en for exactly one cycle on the next cycle, with wr_addr=ADDR and wr_data equal to the byte, then increment ADDR, wrapping 0xFF to 0x00.
REQ-018 SHALL, on SAMPLE data completion with N = the data byte, set busy and load a down-counter with N.
REQ-019 SHALL, while busy, decrement the down-counter each cycle; at 0 it captures sample_in into DOUT, sets dout_valid and clears busy. N=0 captures on the next cycle.
REQ-020 SHALL ignore a SAMPLE command while busy, with the running count unaffected.
REQ-021 SHALL define STATUS as bit0 busy, bit1 dout_valid, bit2 err_illegal_cmd, bit3 err_short_byte, bits7:4 zero.
REQ-022 SHALL, at completion of a RD_STATUS or RD_DOUT command byte, load the tx register with STATUS or DOUT respectively; for all other commands it loads 0x00.
REQ-023 SHALL drive MISO=tx[7] and shift tx left (filling with 0) on each posedge with SSB=0 in the DATA phase; MISO SHALL be 0 whenever SSB=1.
REQ-024 SHALL clear dout_valid at RD_DOUT data completion; if a capture occurs on the same edge, the capture wins and dout_valid stays 1.
REQ-025 SHALL leave wr_en at 0 in every cycle other than the one in REQ-017.

Reset
REQ-026 SHALL, on reset=1 at posedge SCK, set: phase=CMD, bit count=0, rx=0, tx=0, ADDR=0, DOUT=0, busy=0, dout_valid=0, errors=0, MISO=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-027 SHALL abort any byte or sample in progress when reset occurs mid-operation, with no capture or write strobe afterwards.

Configuration
REQ-028 SHALL, with macro SPI_SLAVE_ERR_STATUS_EN defined, set err_illegal_cmd on an illegal command or a SAMPLE received while busy, set err_short_byte per REQ-013, and clear both at RD_STATUS data completion.
REQ-029 SHALL, with SPI_SLAVE_ERR_STATUS_EN undefined, omit the error flags and read STATUS bits 3:2 as 0; all other behaviour is identical.

Structure
REQ-030 SHALL place the command code enum, STATUS bit indices and the DATA_WIDTH constant in the shared package spi_slave_pkg.
REQ-031 SHALL place the bit counter, rx/tx shift registers, byte-done pulse and short-byte detect in sub-module spi_slave_shifter; decode, registers and sampler remain in the top module.

Verification
REQ-032 SHALL cover: bytes 01,AA then 02,BB -> one wr_en pulse with wr_addr=AA and wr_data=BB, after which ADDR=AB.
REQ-033 SHALL cover: bytes 04,03 with sample_in=5C -> busy for 4 cycles after completion, then DOUT=5C, and RD_STATUS returns 0x02 on MISO.
REQ-034 SHALL cover: bytes 03,FF after a sample -> MISO shifts 5C MSB first, and dout_valid is 0 afterwards.
REQ-035 SHALL cover: SSB raised after 5 bits, then 01,DD -> ADDR=DD, and with the macro defined STATUS reads 0x08.
REQ-036 SHALL cover: illegal command 07,11, then 01,FF -> ADDR=FF with no wr_en, and with the macro defined STATUS bit2=1, cleared after that read.
REQ-037 SHALL cover: reset asserted during a SAMPLE count -> busy=0, DOUT=00, and no later capture.
